// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, round functions and core state encoding
package sha256_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINAL, ST_DONE} state_e;

  localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 round; a..h packed with a in [255:224]
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] vars_i,
  input  logic [31:0]  k_i,
  input  logic [31:0]  w_i,
  output logic [255:0] vars_o
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = vars_i;
  assign t1 = h + bsig1(e) + ch(e, f, g) + k_i + w_i;
  assign t2 = bsig0(a) + maj(a, b, c);
  assign vars_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_iter_core.sv
// rtl/sha256_iter_core.sv - iterative SHA-256/224 compression core, ROUNDS_PER_CYCLE rounds per clock
module sha256_iter_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit SUPPORT_224      = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_msg,
  input  logic         in_first,
  input  logic         mode_224,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_hash,
  output logic         busy
);

  localparam int RPC = ROUNDS_PER_CYCLE;

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
    $error("sha256_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_e             state_q, state_d;
  logic [255:0]       h_q, h_d;
  logic [255:0]       vars_q, vars_d;
  logic [15:0][31:0]  w_q, w_d;
  logic [6:0]         round_q, round_d;
  logic               mode_q, mode_d;
  logic [255:0]       hash_q, hash_d;

  logic [31:0]        w_ext [16+RPC];
  logic [RPC:0][255:0] chain;

  // w_q[0] is W[round]; the window is extended by RPC words so every round of this cycle sees its W.
  always_comb begin
    for (int i = 0; i < 16; i++) w_ext[i] = w_q[i];
    for (int j = 0; j < RPC; j++)
      w_ext[16+j] = ssig1(w_ext[14+j]) + w_ext[9+j] + ssig0(w_ext[1+j]) + w_ext[j];
  end

  assign chain[0] = vars_q;
  for (genvar j = 0; j < RPC; j++) begin : g_round
    logic [5:0] kidx;
    assign kidx = round_q[5:0] + 6'(j);
    sha256_round u_round (
      .vars_i (chain[j]),
      .k_i    (K_TABLE[kidx]),
      .w_i    (w_q[j]),
      .vars_o (chain[j+1])
    );
  end

  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_hash  = hash_q;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    vars_d  = vars_q;
    w_d     = w_q;
    round_d = round_q;
    mode_d  = mode_q;
    hash_d  = hash_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          for (int i = 0; i < 16; i++) w_d[i] = in_msg[511-32*i -: 32];
          // h_q doubles as H_base: it holds the value the final feed-forward adds to.
          if (in_first) begin
            mode_d = SUPPORT_224 && mode_224;
            h_d    = mode_d ? IV224 : IV256;
          end
          vars_d  = h_d;
          round_d = 7'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        vars_d = chain[RPC];
        for (int i = 0; i < 16; i++) w_d[i] = w_ext[i+RPC];
        round_d = round_q + 7'(RPC);
        if (round_d == 7'd64) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        for (int i = 0; i < 8; i++) h_d[32*i +: 32] = h_q[32*i +: 32] + vars_q[32*i +: 32];
        hash_d  = mode_q ? {h_d[255:32], 32'h0} : h_d;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      vars_q  <= '0;
      w_q     <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
      hash_q  <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      vars_q  <= vars_d;
      w_q     <= w_d;
      round_q <= round_d;
      mode_q  <= mode_d;
      hash_q  <= hash_d;
    end
  end

endmodule
